// File: rtl/pipe_rr_sched_pkg.sv
// Shared constants for the two-requester round-robin pipeline scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pipe_rr_sched_pkg;

  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_rr_sched_if.sv
// Requester, sink and control bundle of the round-robin pipeline scheduler.
// Latency: none (wires only).
// Backpressure: out_ready from the sink stalls the pipe; readies go back to the requesters.
interface pipe_rr_sched_if #(
  parameter int M  = 3,
  parameter int CW = 3
) ();

  logic          req0_valid;
  logic [M-1:0]  req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [M-1:0]  req1_data;
  logic          req1_ready;
  logic          out_valid;
  logic [M-1:0]  out_data;
  logic          out_src;
  logic          out_ready;
  logic          flush;
  logic          drain;
  logic          drained;
  logic [CW-1:0] occupancy;
  logic          busy;

  // Producer/sink/controller side.
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready, flush, drain,
    input  req0_ready, req1_ready, out_valid, out_data, out_src, drained, occupancy, busy
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready, flush, drain,
    output req0_ready, req1_ready, out_valid, out_data, out_src, drained, occupancy, busy
  );

endinterface

// File: rtl/pipe_stage.sv
// One register stage of the shared pipeline: valid bit, data word and source tag.
// Latency: 1 cycle when enabled.
// Backpressure: holds everything while en is low; clr drops only the valid bit.
module pipe_stage #(
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         d_valid,
  input  logic [M-1:0] d_data,
  input  logic         d_src,
  output logic         q_valid,
  output logic [M-1:0] q_data,
  output logic         q_src
);

  // Valid obeys clear first; payload just follows the enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_src   <= 1'b0;
    end else begin
      if (clr) begin
        q_valid <= 1'b0;
      end else if (en) begin
        q_valid <= d_valid;
      end
      if (en) begin
        q_data <= d_data;
        q_src  <= d_src;
      end
    end
  end

endmodule

// File: rtl/pipe_rr_sched.sv
// Round-robin merge of two requesters into an N-stage shared pipeline, with flush/drain control.
// Latency: N cycles from accept to out_valid when the sink never stalls.
// Backpressure: out_ready low with a valid output freezes the whole pipe and drops both readies.
module pipe_rr_sched
  import pipe_rr_sched_pkg::*;
#(
  parameter int M  = 3,
  parameter int N  = 4,
  parameter int CW = 3
) (
  input logic            clk,
  input logic            rst,
  pipe_rr_sched_if.slave bus
);

  localparam int DW = N * M;

  state_t        state;
  logic          last_grant;
  logic          drain_ack;
  logic          drained_q;
  logic [CW-1:0] occ;
  logic [CW-1:0] occ_next;

  logic          adv;
  logic          acc_en;
  logic          grant;
  logic          xfer;
  logic          pop;
  logic          in_src;
  logic [M-1:0]  in_data;

  logic [N-1:0]  d_v, q_v, d_s, q_s;
  logic [DW-1:0] d_d, q_d;

  // Advance, arbitration and next occupancy.
  always_comb begin
    adv      = !q_v[N-1] || bus.out_ready;
    acc_en   = !rst && adv && !bus.flush && !bus.drain && (state != ST_DRAIN);
    grant    = bus.req1_valid && (!bus.req0_valid || (last_grant == SRC_REQ0));
    xfer     = acc_en && (grant ? bus.req1_valid : bus.req0_valid);
    pop      = q_v[N-1] && bus.out_ready;
    in_src   = grant ? SRC_REQ1 : SRC_REQ0;
    in_data  = grant ? bus.req1_data : bus.req0_data;
    occ_next = bus.flush ? '0 : (occ + CW'(xfer) - CW'(pop));
  end

  // Stage k input is stage k-1 output; stage 1 input is the granted word or a bubble.
  assign d_v = N'({q_v, xfer});
  assign d_s = N'({q_s, in_src});
  assign d_d = DW'({q_d, in_data});

  pipe_stage #(.M(M)) u_stage [N-1:0] (
    .clk     (clk),
    .rst     (rst),
    .en      (adv),
    .clr     (bus.flush),
    .d_valid (d_v),
    .d_data  (d_d),
    .d_src   (d_s),
    .q_valid (q_v),
    .q_data  (q_d),
    .q_src   (q_s)
  );

  // Control FSM; drain_ack suppresses repeat pulses while drain stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= SRC_REQ1;
      occ        <= '0;
      drained_q  <= 1'b0;
      drain_ack  <= 1'b0;
    end else begin
      occ       <= occ_next;
      drained_q <= 1'b0;
      drain_ack <= drain_ack && bus.drain;
      if (xfer) begin
        last_grant <= grant;
      end
      if (bus.flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.drain) begin
              if (!drain_ack) begin
                drained_q <= 1'b1;
                drain_ack <= 1'b1;
              end
            end else if (xfer) begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (bus.drain) begin
              if (occ_next == '0) begin
                drained_q <= 1'b1;
                drain_ack <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                state <= ST_DRAIN;
              end
            end else if (occ_next == '0) begin
              state <= ST_IDLE;
            end
          end
          ST_DRAIN: begin
            if (occ_next == '0) begin
              drained_q <= 1'b1;
              drain_ack <= bus.drain;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.req0_ready = acc_en && !grant;
  assign bus.req1_ready = acc_en && grant;
  assign bus.out_valid  = q_v[N-1];
  assign bus.out_data   = q_d[DW-1 -: M];
  assign bus.out_src    = q_s[N-1];
  assign bus.occupancy  = occ;
  assign bus.busy       = (occ != '0);
  assign bus.drained    = drained_q;

endmodule

// File: tb/tb_pipe_rr_sched.sv
// Self-checking bench for pipe_rr_sched against a queue-of-words reference model.
// Latency: checks N-cycle accept-to-output through the model's per-word age.
// Backpressure: exercises sink stalls, flush, drain and asynchronous reset.
module tb_pipe_rr_sched;
  import pipe_rr_sched_pkg::*;

  localparam int M  = 3;
  localparam int N  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_rr_sched_if #(.M(M), .CW(CW)) bus ();

  pipe_rr_sched #(.M(M), .N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: words in flight, each aged by the number of advances since acceptance.
  typedef struct {
    logic [M-1:0] data;
    logic         src;
    int           age;
  } word_t;

  word_t q[$];
  logic  m_last;
  bit    m_drain_active;
  bit    m_acked;
  logic  m_drained;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [M-1:0] d0, input logic v1,
                       input logic [M-1:0] d1, input logic ordy, input logic fl, input logic dr);
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    bus.out_ready  = ordy;
    bus.flush      = fl;
    bus.drain      = dr;
  endtask

  task automatic model_reset();
    q.delete();
    m_last         = 1'b1;
    m_drain_active = 1'b0;
    m_acked        = 1'b0;
    m_drained      = 1'b0;
  endtask

  // One clock cycle: drive, check against the model, take the edge, update the model.
  task automatic cycle(input logic v0, input logic [M-1:0] d0, input logic v1,
                       input logic [M-1:0] d1, input logic ordy, input logic fl, input logic dr);
    logic  ov, adv, acc, gnt, e0, e1, xfer;
    word_t w;
    drive(v0, d0, v1, d1, ordy, fl, dr);
    #2;
    ov  = (q.size() > 0) && (q[0].age == N);
    adv = !ov || ordy;
    acc = adv && !fl && !dr && !m_drain_active;
    gnt = (v0 && v1) ? !m_last : v1;
    e0  = acc && !gnt;
    e1  = acc && gnt;
    chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
    chk("out_valid", 32'(bus.out_valid), 32'(ov));
    if (ov) begin
      chk("out_data", 32'(bus.out_data), 32'(q[0].data));
      chk("out_src", 32'(bus.out_src), 32'(q[0].src));
    end
    chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
    chk("busy", 32'(bus.busy), 32'(q.size() != 0));
    chk("drained", 32'(bus.drained), 32'(m_drained));
    @(posedge clk);
    xfer      = gnt ? (e1 && v1) : (e0 && v0);
    m_drained = 1'b0;
    if (fl) begin
      q.delete();
      m_drain_active = 1'b0;
      m_acked        = m_acked && dr;
    end else begin
      if (adv) begin
        if (ov) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (xfer) begin
          w.data = gnt ? d1 : d0;
          w.src  = gnt;
          w.age  = 1;
          q.push_back(w);
        end
      end
      if (m_drain_active || (dr && !m_acked)) begin
        if (q.size() == 0) begin
          m_drained      = 1'b1;
          m_drain_active = 1'b0;
          m_acked        = dr;
        end else begin
          m_drain_active = 1'b1;
        end
      end else begin
        m_acked = m_acked && dr;
      end
    end
    if (xfer) m_last = gnt;
    #1;
  endtask

  logic drain_lvl;

  initial begin
    // Reset with requesters already valid: every output must be 0.
    rst = 1'b1;
    drive(1'b1, 3'h5, 1'b1, 3'h2, 1'b1, 1'b0, 1'b0);
    model_reset();
    #12;
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_src", 32'(bus.out_src), 32'd0);
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_drained", 32'(bus.drained), 32'd0);
    drive(1'b0, 3'h0, 1'b0, 3'h0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single req0 word travels N stages.
    cycle(1'b1, 3'h5, 1'b0, 3'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 3'h0, 1'b0, 3'h0, 1'b1, 1'b0, 1'b0);

    // Both requesters valid: alternating grants.
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'h1, 1'b1, 3'h2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 3'h0, 1'b0, 3'h0, 1'b1, 1'b0, 1'b0);

    // Fill under a stalled sink, hold 3 cycles, then release.
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'(i), 1'b1, 3'(i + 4), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'h7, 1'b1, 3'h6, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'h3, 1'b1, 3'h4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 3'h0, 1'b0, 3'h0, 1'b1, 1'b0, 1'b0);

    // Flush with three words in flight and req0 valid.
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'(i + 1), 1'b0, 3'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 3'h6, 1'b0, 3'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'h0, 1'b0, 3'h0, 1'b1, 1'b0, 1'b0);

    // Drain with two words in flight, requesters still valid.
    for (int i = 0; i < 2; i++) cycle(1'b1, 3'(i + 5), 1'b1, 3'(i + 2), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 3'h1, 1'b1, 3'h2, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 3'h0, 1'b0, 3'h0, 1'b1, 1'b0, 1'b0);

    // Drain on an empty pipe: one pulse, no repeat while held.
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'h0, 1'b0, 3'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 3'h0, 1'b0, 3'h0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    drain_lvl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) drain_lvl = !drain_lvl;
      cycle(1'($urandom_range(0, 1)), M'($urandom), 1'($urandom_range(0, 1)), M'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0), drain_lvl);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 3'h0, 1'b0, 3'h0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-stream, between edges.
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'h3, 1'b1, 3'h4, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'h3, 1'b1, 3'h4, 1'b1, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("arst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("arst_req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("arst_drained", 32'(bus.drained), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    model_reset();
    drive(1'b0, 3'h0, 1'b0, 3'h0, 1'b1, 1'b0, 1'b0);
    #4;
    rst = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, 3'h3, 1'b1, 3'h4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 3'h3, 1'b1, 3'h4, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
